// File: rtl/draw_image_blit.sv
// Raster image blitter: walks an IMG_W x IMG_H ROM, offsets each pixel by a latched origin,
// clips to the screen, optionally drops a key colour, and emits registered VGA writes.
module draw_image_blit #(
  parameter int                    IMG_W      = 160,
  parameter int                    IMG_H      = 120,
  parameter int                    SCREEN_W   = 160,
  parameter int                    SCREEN_H   = 120,
  parameter int                    COLOUR_W   = 9,
  parameter int                    ADDR_W     = 15,
  parameter int                    ROM_LAT    = 1,
  parameter int                    KEY_EN     = 0,
  parameter logic [COLOUR_W-1:0]   KEY_COLOUR = {COLOUR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          x0,
  input  logic [6:0]          y0,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic                busy,
  output logic                done,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [2:0]        DRAIN_END = 3'(ROM_LAT);
  localparam int                TAIL      = ROM_LAT - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [7:0]                  x0_q, x0_d;
  logic [6:0]                  y0_q, y0_d;
  logic [2:0]                  drain_q, drain_d;
  logic [ROM_LAT-1:0]          vld_q, vld_d;
  logic [ROM_LAT-1:0][8:0]     sx_q, sx_d;
  logic [ROM_LAT-1:0][7:0]     sy_q, sy_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [7:0]                  x_q, x_d;
  logic [6:0]                  y_q, y_d;
  logic [COLOUR_W-1:0]         colour_q, colour_d;
  logic                        plot_q, plot_d;
  logic                        pix_ok;

  assign rom_addr = ADDR_W'(row_q) * IMG_W_A + ADDR_W'(col_q);

  // Next-state, counter, delay-line and output-register logic
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    vld_d    = vld_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    for (int i = ROM_LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      sx_d[i]  = sx_q[i-1];
      sy_d[i]  = sy_q[i-1];
    end
    // Stage 0 always carries the coordinates of the address currently on rom_addr
    vld_d[0] = 1'b0;
    sx_d[0]  = 9'(x0_q) + 9'(col_q);
    sy_d[0]  = 8'(y0_q) + 8'(row_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        vld_d[0] = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            drain_d = 3'd0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_END) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pix_ok = vld_q[TAIL]
             && (sx_q[TAIL] < 9'(SCREEN_W))
             && (sy_q[TAIL] < 8'(SCREEN_H))
             && !((KEY_EN != 0) && (rom_q == KEY_COLOUR));
    plot_d = pix_ok;
    if (pix_ok) begin
      x_d      = sx_q[TAIL][7:0];
      y_d      = sy_q[TAIL][6:0];
      colour_d = rom_q;
    end else begin
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
    end
  end

  // State and output registers; reset aborts any draw without a done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      x0_q     <= 8'd0;
      y0_q     <= 7'd0;
      drain_q  <= 3'd0;
      vld_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      drain_q  <= drain_d;
      vld_q    <= vld_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule
